uart_tx_frm: RTL and testbench
==============================

Name: uart_tx_frm

Overview:
- Synthesizable, parametrised UART transmitter; successor to the fixed 8N1 behavioural line driver used in the top-level bench.
- Serialises words with configurable data width, parity mode, stop-bit count and baud divider.
- Takes words over a valid/ready handshake from the command/response path and drives the board uart_tx pin.
- The same block also serves as the bench stimulus source for the UART receive path.

Parameters:
- CLK_DIV, 868: clock cycles per bit period; legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even; 3 is illegal.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tx_data  in  DATA_BITS  word to send; sampled only on accept.
- tx_valid  in  1  word present on tx_data.
- tx_ready  out  1  block can accept a word this cycle.
- uart_tx  out  1  serial line; idle level is high.
- tx_busy  out  1  a frame is in progress.
- tx_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Values while rst is high and on the cycle after it: uart_tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0.
- Reset during a frame: the frame is abandoned and the line returns high on the next clk edge. No partial stop bit is sent.
- States: IDLE -> START -> DATA -> PAR -> STOP -> IDLE. PAR is skipped when PARITY=0.
- Accept: a word is accepted when tx_valid & tx_ready at a rising edge.
  - tx_data is latched into the shift register.
  - The parity bit is computed from the latched word.
  - Next state is START. tx_ready falls and tx_busy rises on the cycle after accept.
- tx_ready is 1 only in IDLE. tx_busy = !IDLE.
- Baud counter: reloads at 0 on every state or bit change. Each bit lasts exactly CLK_DIV cycles; the bit advances when the counter reaches CLK_DIV-1.
- Line output: uart_tx is registered.
  - START drives 0.
  - DATA drives shift[0], shifting right once per bit period, for DATA_BITS bits.
  - PAR drives the parity bit: odd = ~^data, even = ^data.
  - STOP drives 1 for STOP_BITS periods.
- Latency: the first start-bit cycle appears on uart_tx on the cycle after accept.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- tx_done is high for exactly one cycle: the last cycle of the last stop bit. On the next cycle the state is IDLE.
- Back-to-back frames: with tx_valid held high, the word is accepted in the first IDLE cycle. Exactly one extra idle-high clock separates the end of one frame's stop bits from the start bit of the next frame.
- Input handling: tx_data changes after accept do not affect the frame in flight. tx_valid without tx_ready is ignored; no word is lost, the source holds it.
- Illegal parameter values fail elaboration (generate-time check). Behaviour under them is not defined.
- Size: implementation is about 150-250 lines, covering the FSM, baud counter, bit counter, shift register and parity logic.

Test Plan:
1. CLK_DIV=4, 8N1, send 0x85 → uart_tx low for 4 cycles, then bits 1,0,1,0,0,0,0,1 at 4 cycles each, then high. tx_done pulses on the 40th cycle after accept. tx_ready returns on cycle 41.
2. CLK_DIV=4, PARITY=2 (even), send 0x85 → parity bit 1, frame 44 cycles. With PARITY=1 (odd), send 0x85 → parity bit 0. Send 0x00 with even parity → parity bit 0.
3. DATA_BITS=7, STOP_BITS=2, CLK_DIV=3, send 0x55 → 7 data bits 1,0,1,0,1,0,1, then 6 high stop cycles. tx_done lands on the last of those 6 cycles. Frame 30 cycles.
4. Back-to-back: tx_valid held high with 0x01, 0x00, 0x85, 0xAA, CLK_DIV=4, 8N1 → four frames, each 40 cycles plus 1 idle cycle between them. Receiver model decodes 01 00 85 AA in order.
5. Assert rst for 1 cycle midway through the DATA bits of 0xAA → uart_tx=1, tx_ready=1, tx_busy=0 on the next cycle. A new word sent afterwards produces a clean frame.
6. Handshake hold-off: tx_valid pulses during busy with tx_data toggling → no accept while busy. The frame in flight transmits the originally latched word unchanged.

Source files
------------

// File: rtl/uart_tx_frm.sv
// -----------------------------------------------------------------------------
// uart_tx_frm
// Parametrised UART transmitter. Accepts one word over a valid/ready handshake
// and serialises it as: start bit (0), DATA_BITS data bits LSB first, optional
// parity bit, then STOP_BITS stop bits (1). Every bit lasts CLK_DIV clocks.
//
// Parameters
//   CLK_DIV    clock cycles per bit period (2..65535)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   tx_data   in   word to send, sampled only on the accepting edge
//   tx_valid  in   a word is present on tx_data
//   tx_ready  out  block can accept a word this cycle (IDLE only)
//   uart_tx   out  registered serial line, idle high
//   tx_busy   out  a frame is in progress
//   tx_done   out  one-cycle pulse on the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_frm #(
    parameter int CLK_DIV   = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if ((CLK_DIV < 2) || (CLK_DIV > 65535)) begin : g_bad_clk_div
        $error("uart_tx_frm: CLK_DIV out of range 2..65535");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_frm: DATA_BITS out of range 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx_frm: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_frm: STOP_BITS must be 1 or 2");
    end

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic        HAS_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic        PAR_ODD   = (PARITY == 1) ? 1'b1 : 1'b0;

    // Parity bit for a word: odd parity inverts the XOR reduction so that the
    // total count of ones (data + parity) is odd.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] word,
                                         input logic                 odd);
        logic x;
        x = ^word;
        return odd ? ~x : x;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]           state_q,   state_d;
    logic [15:0]          baud_q,    baud_d;
    logic [3:0]           bit_q,     bit_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 par_q,     par_d;
    logic                 uart_tx_q, uart_tx_d;
    logic                 ready_q,   ready_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic                 accept_s;
    logic                 bit_end_s;

    assign accept_s  = tx_valid & ready_q;
    assign bit_end_s = (baud_q == BAUD_LAST);

    // Next-state logic: FSM, baud counter, bit counter, shift register, parity
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                bit_d  = 4'd0;
                if (accept_s) begin
                    state_d = S_START;
                    shift_d = tx_data;
                    par_d   = calc_parity(tx_data, PAR_ODD);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d = S_DATA;
                    baud_d  = 16'd0;
                    bit_d   = 4'd0;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_d  = 16'd0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 4'd0;
                        state_d = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            S_PAR: begin
                if (bit_end_s) begin
                    state_d = S_STOP;
                    baud_d  = 16'd0;
                    bit_d   = 4'd0;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    baud_d = 16'd0;
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = 16'd0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they describe (no extra cycle of latency on the line).
    always_comb begin
        uart_tx_d = 1'b1;
        case (state_d)
            S_START: uart_tx_d = 1'b0;
            S_DATA:  uart_tx_d = shift_d[0];
            S_PAR:   uart_tx_d = par_d;
            S_STOP:  uart_tx_d = 1'b1;
            default: uart_tx_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        // Pulse on the final baud tick of the final stop bit.
        done_d  = (state_d == S_STOP) && (bit_d == STOP_LAST) &&
                  (baud_d == BAUD_LAST);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= 16'd0;
            bit_q     <= 4'd0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            uart_tx_q <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            uart_tx_q <= uart_tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign uart_tx  = uart_tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frm.sv
// Directed bench for uart_tx_frm. Four instances cover 8N1, 8E1, 8O1 and 7N2.
module tb_uart_tx_frm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] vld = 4'b0000;
    logic [8:0] dat [4];
    logic [3:0] utx, done, rdy, busy;

    int checks   = 0;
    int failures = 0;

    logic cap_line [0:255];
    logic cap_done [0:255];
    logic cap_rdy  [0:255];
    logic cap_busy [0:255];

    always #5 clk = ~clk;

    uart_tx_frm #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
        .clk(clk), .rst(rst), .tx_data(dat[0][7:0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .uart_tx(utx[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frm #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e81 (
        .clk(clk), .rst(rst), .tx_data(dat[1][7:0]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .uart_tx(utx[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frm #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o81 (
        .clk(clk), .rst(rst), .tx_data(dat[2][7:0]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .uart_tx(utx[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_frm #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_n72 (
        .clk(clk), .rst(rst), .tx_data(dat[3][6:0]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .uart_tx(utx[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present word w on instance k, wait for accept, then record total+1 cycles.
    // With disturb set, tx_valid pulses and tx_data toggles during the frame.
    task automatic send_capture(input int k, input logic [8:0] w, input int total,
                                input bit disturb);
        int guard;
        guard  = 0;
        dat[k] = w;
        vld[k] = 1'b1;
        while (!rdy[k] && guard < 200) begin
            tick();
            guard++;
        end
        chk("accept_wait", 16'(guard < 200), 16'd1);
        tick();
        vld[k] = 1'b0;
        for (int c = 1; c <= total + 1; c++) begin
            cap_line[c] = utx[k];
            cap_done[c] = done[k];
            cap_rdy[c]  = rdy[k];
            cap_busy[c] = busy[k];
            if (disturb) begin
                vld[k] = (c < total - 2) ? c[0] : 1'b0;
                dat[k] = 9'($urandom);
            end
            tick();
        end
    endtask

    // pat bit i is the expected line level during frame bit i (bit 0 = start).
    task automatic check_frame(input logic [11:0] pat, input int div, input int total,
                               input string tag);
        for (int c = 1; c <= total; c++) begin
            chk({tag, "_line"}, 16'(cap_line[c]), 16'(pat[(c - 1) / div]));
            chk({tag, "_done"}, 16'(cap_done[c]), 16'(c == total));
            chk({tag, "_ready"}, 16'(cap_rdy[c]), 16'd0);
            chk({tag, "_busy"}, 16'(cap_busy[c]), 16'd1);
        end
        chk({tag, "_end_line"},  16'(cap_line[total + 1]), 16'd1);
        chk({tag, "_end_ready"}, 16'(cap_rdy[total + 1]),  16'd1);
        chk({tag, "_end_busy"},  16'(cap_busy[total + 1]), 16'd0);
        chk({tag, "_end_done"},  16'(cap_done[total + 1]), 16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] words [4];
        int         starts [4];
        int         idx;
        logic       acc;
        logic [7:0] rx;

        for (int i = 0; i < 4; i++) dat[i] = 9'd0;

        // Reset: values while rst is high and on the cycle after release
        rst = 1'b1;
        tick();
        tick();
        chk("rst_line",  16'(utx),  16'hF);
        chk("rst_ready", 16'(rdy),  16'hF);
        chk("rst_busy",  16'(busy), 16'h0);
        chk("rst_done",  16'(done), 16'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_line",  16'(utx),  16'hF);
        chk("post_rst_ready", 16'(rdy),  16'hF);
        chk("post_rst_busy",  16'(busy), 16'h0);
        chk("post_rst_done",  16'(done), 16'h0);

        // 1: 8N1 0x85 -> 0,1,0,1,0,0,0,0,1,1
        send_capture(0, 9'h085, 40, 1'b0);
        check_frame(12'h30A, 4, 40, "n81_85");

        // 2: even parity 0x85 -> parity 1; odd 0x85 -> parity 0; even 0x00 -> 0
        send_capture(1, 9'h085, 44, 1'b0);
        check_frame(12'h70A, 4, 44, "e81_85");
        send_capture(2, 9'h085, 44, 1'b0);
        check_frame(12'h50A, 4, 44, "o81_85");
        send_capture(1, 9'h000, 44, 1'b0);
        check_frame(12'h400, 4, 44, "e81_00");

        // 3: 7N2 div 3, 0x55 -> 0,1,0,1,0,1,0,1,1,1 ; 30 cycles
        send_capture(3, 9'h055, 30, 1'b0);
        check_frame(12'h3AA, 3, 30, "n72_55");

        // 4: back-to-back with tx_valid held high
        words[0] = 8'h01; words[1] = 8'h00; words[2] = 8'h85; words[3] = 8'hAA;
        for (int i = 0; i < 4; i++) starts[i] = 1;
        idx    = 0;
        dat[0] = {1'b0, words[0]};
        vld[0] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cap_line[c] = utx[0];
            acc = rdy[0] & vld[0];
            tick();
            if (acc) begin
                starts[idx] = c + 1;
                idx++;
                if (idx < 4) dat[0] = {1'b0, words[idx]};
                else         vld[0] = 1'b0;
            end
        end
        vld[0] = 1'b0;
        chk("b2b_accepts", 16'(idx), 16'd4);
        for (int i = 1; i < 4; i++) begin
            chk("b2b_gap", 16'(starts[i] - starts[i - 1]), 16'd41);
            chk("b2b_idle_line", 16'(cap_line[starts[i] - 1]), 16'd1);
        end
        for (int i = 0; i < 4; i++) begin
            rx = 8'h00;
            for (int j = 0; j < 8; j++) rx[j] = cap_line[starts[i] + 4 * (1 + j) + 2];
            chk("b2b_start_bit", 16'(cap_line[starts[i] + 2]), 16'd0);
            chk("b2b_stop_bit",  16'(cap_line[starts[i] + 38]), 16'd1);
            chk("b2b_rx_word",   16'(rx), 16'(words[i]));
        end

        // 5: reset during the data bits of 0xAA, then a clean frame
        dat[0] = 9'h0AA;
        vld[0] = 1'b1;
        idx    = 0;
        while (!rdy[0] && idx < 200) begin
            tick();
            idx++;
        end
        tick();
        vld[0] = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        chk("mid_frame_line", 16'(utx[0]), 16'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_line",  16'(utx[0]),  16'd1);
        chk("abort_ready", 16'(rdy[0]),  16'd1);
        chk("abort_busy",  16'(busy[0]), 16'd0);
        chk("abort_done",  16'(done[0]), 16'd0);
        send_capture(0, 9'h085, 40, 1'b0);
        check_frame(12'h30A, 4, 40, "after_abort_85");

        // 6: tx_valid pulses and tx_data toggles while busy
        send_capture(0, 9'h085, 40, 1'b1);
        check_frame(12'h30A, 4, 40, "holdoff_85");
        vld[0] = 1'b0;
        tick();
        tick();
        chk("holdoff_no_accept_busy", 16'(busy[0]), 16'd0);
        chk("holdoff_no_accept_line", 16'(utx[0]),  16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
